// File: rtl/gbuff_arbiter.sv
// Round-robin arbiter that shares the single-port global buffer between the
// host loader, operand fetch and result writeback, one whole burst at a time.
module gbuff_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  input  logic [3*LEN_W-1:0]    len,
  output logic [2:0]            gnt,
  output logic [2:0]            done,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  gb_wr_en,
  output logic [ADDR_W-1:0]     gb_index,
  output logic [DATA_W-1:0]     gb_data_in,
  input  logic [DATA_W-1:0]     gb_data_out,
  output logic                  dbg_state
);

  // Handshake: req[i] is a held request and gnt[i] is the per-beat ready.
  // A beat of requester i transfers in every cycle gnt[i] is high; the
  // requester must hold wdata for a beat until it has seen gnt for that
  // beat, and may drop req at any time after the grant without effect.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q;
  logic [1:0]          owner_q;
  logic [1:0]          winner;
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [LEN_W-1:0]    lat_len_q;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [2:0]          rvalid_q;
  logic                grant_now;

  // Search starts one past the last owner so a requester that keeps req
  // asserted yields to any other pending requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                         input logic [2:0] r);
    logic [1:0] cand;
    logic [1:0] res;
    logic       found;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(ptr) + k) % 3);
      if (!found && r[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign winner    = rr_pick(rr_ptr_q, req);
  assign grant_now = (state_q == IDLE) && (|req);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    gnt        = 3'b000;
    done       = 3'b000;
    gb_wr_en   = 1'b0;
    gb_index   = '0;
    gb_data_in = '0;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        if (|req) begin
          state_d = BURST;
        end
      end
      BURST: begin
        gnt        = 3'b001 << owner_q;
        gb_wr_en   = lat_we_q;
        gb_index   = lat_addr_q + ADDR_W'(beat_q);
        gb_data_in = wdata[owner_q*DATA_W +: DATA_W];
        if (beat_q == lat_len_q) begin
          done    = 3'b001 << owner_q;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd2;
      owner_q    <= 2'd0;
      beat_q     <= '0;
      lat_we_q   <= 1'b0;
      lat_addr_q <= '0;
      lat_len_q  <= '0;
      rvalid_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      // The buffer registers read data, so the strobe trails the read grant.
      rvalid_q <= gnt & {3{~lat_we_q}};
      if (grant_now) begin
        owner_q    <= winner;
        rr_ptr_q   <= winner;
        lat_we_q   <= we[winner];
        lat_addr_q <= addr[winner*ADDR_W +: ADDR_W];
        lat_len_q  <= len[winner*LEN_W +: LEN_W];
      end
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = (|rvalid_q) ? gb_data_out : '0;
  assign dbg_state = (state_q == BURST);

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Directed bench for gbuff_arbiter with a behavioural 256x32 registered-read
// buffer attached to the gb_* port.
module tb_gbuff_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [23:0] addr;
  logic [95:0] wdata;
  logic [11:0] len;
  logic [2:0]  gnt, done, rvalid;
  logic [31:0] rdata;
  logic        gb_wr_en;
  logic [7:0]  gb_index;
  logic [31:0] gb_data_in;
  logic [31:0] gb_data_out;
  logic        dbg_state;

  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gbuff_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .len(len), .gnt(gnt), .done(done), .rvalid(rvalid), .rdata(rdata),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_data_in(gb_data_in),
    .gb_data_out(gb_data_out), .dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (gb_wr_en) mem[gb_index] <= gb_data_in;
    gb_data_out <= mem[gb_index];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [7:0] a,
                         input logic [3:0] l, input logic [31:0] d);
    we[i]          = w;
    addr[i*8 +: 8] = a;
    len[i*4 +: 4]  = l;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},    32'(gnt), 32'h0);
    chk({tag, "_done"},   32'(done), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_wr_en"},  32'(gb_wr_en), 32'h0);
    chk({tag, "_index"},  32'(gb_index), 32'h0);
    chk({tag, "_state"},  32'(dbg_state), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; len = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    cyc();

    // Single write: requester 0, 0x10..0x13, data A0..A3
    set_req(0, 1'b1, 8'h10, 4'd3, 32'hA0);
    req = 3'b001;
    #1 chk("wr_idle_gnt", 32'(gnt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) req = 3'b000;
      wdata[31:0] = 32'hA0 + k;
      #1;
      chk("wr_gnt",   32'(gnt), 32'h1);
      chk("wr_index", 32'(gb_index), 32'h10 + k);
      chk("wr_en",    32'(gb_wr_en), 32'h1);
      chk("wr_data",  gb_data_in, 32'hA0 + k);
      chk("wr_done",  32'(done), (k == 3) ? 32'h1 : 32'h0);
    end
    cyc();
    #1;
    chk("wr_after_gnt",   32'(gnt), 32'h0);
    chk("wr_after_state", 32'(dbg_state), 32'h0);

    // Read back by requester 1
    set_req(1, 1'b0, 8'h10, 4'd3, 32'h0);
    req = 3'b010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k == 0) req = 3'b000;
      #1;
      if (k < 4) begin
        chk("rd_gnt",   32'(gnt), 32'h2);
        chk("rd_wr_en", 32'(gb_wr_en), 32'h0);
        chk("rd_index", 32'(gb_index), 32'h10 + k);
      end else begin
        chk("rd_end_gnt", 32'(gnt), 32'h0);
      end
      chk("rd_rvalid", 32'(rvalid), (k == 0) ? 32'h0 : 32'h2);
      if (k > 0) chk("rd_rdata", rdata, 32'hA0 + k - 1);
    end

    // Index wrap: requester 2 writes 0xFE, 0xFF, 0x00
    set_req(2, 1'b1, 8'hFE, 4'd2, 32'hC0);
    req = 3'b100;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) req = 3'b000;
      wdata[64 +: 32] = 32'hC0 + k;
      #1;
      chk("wrap_gnt",   32'(gnt), 32'h4);
      chk("wrap_index", 32'(gb_index), (32'hFE + k) & 32'hFF);
      chk("wrap_done",  32'(done), (k == 2) ? 32'h4 : 32'h0);
    end
    cyc();
    #1 chk("wrap_after_gnt", 32'(gnt), 32'h0);
    set_req(0, 1'b0, 8'hFF, 4'd1, 32'h0);
    req = 3'b001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) req = 3'b000;
      #1;
      if (k < 2) chk("wraprd_gnt", 32'(gnt), 32'h1);
      if (k > 0) begin
        chk("wraprd_rvalid", 32'(rvalid), 32'h1);
        chk("wraprd_rdata",  rdata, 32'hC0 + k);
      end
    end

    // Fairness after reset: 0,1,2,0,1,2 with one bubble between grants
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 1'b0, 8'h00, 4'd0, 32'h0);
    set_req(1, 1'b0, 8'h00, 4'd0, 32'h0);
    set_req(2, 1'b0, 8'h00, 4'd0, 32'h0);
    req = 3'b111;
    #1 chk("fair_idle_gnt", 32'(gnt), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      #1;
      chk("fair_gnt",  32'(gnt), 32'h1 << (i % 3));
      chk("fair_done", 32'(done), 32'h1 << (i % 3));
      cyc();
      #1 chk("fair_bubble", 32'(gnt), 32'h0);
    end
    req = 3'b000;

    // Late request and mid-burst addr change
    set_req(1, 1'b1, 8'h20, 4'd2, 32'hB0);
    req = 3'b010;
    cyc();
    set_req(0, 1'b0, 8'h10, 4'd0, 32'h0);
    req = 3'b011;
    #1;
    chk("late_gnt0",  32'(gnt), 32'h2);
    chk("late_index0", 32'(gb_index), 32'h20);
    chk("late_data0", gb_data_in, 32'hB0);
    cyc();
    addr[15:8] = 8'h80;
    wdata[63:32] = 32'hB1;
    #1;
    chk("late_gnt1",   32'(gnt), 32'h2);
    chk("late_index1", 32'(gb_index), 32'h21);
    cyc();
    wdata[63:32] = 32'hB2;
    #1;
    chk("late_index2", 32'(gb_index), 32'h22);
    chk("late_done",   32'(done), 32'h2);
    cyc();
    #1 chk("late_bubble", 32'(gnt), 32'h0);
    cyc();
    req = 3'b000;
    #1;
    chk("late_gnt_req0", 32'(gnt), 32'h1);
    chk("late_idx_req0", 32'(gb_index), 32'h10);
    chk("late_done_req0", 32'(done), 32'h1);
    cyc();
    #1;
    chk("late_rvalid", 32'(rvalid), 32'h1);
    chk("late_rdata",  rdata, 32'hA0);

    // Reset during beat 2 of a len=7 write over 0x10..
    set_req(0, 1'b1, 8'h10, 4'd7, 32'hD0);
    req = 3'b001;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 0) req = 3'b000;
      wdata[31:0] = 32'hD0 + k;
      #1 chk("abort_gnt", 32'(gnt), 32'h1);
    end
    rst = 1'b1;
    #1 chk_reset_outputs("abort");
    cyc();
    chk("abort_hold_gnt",  32'(gnt), 32'h0);
    chk("abort_hold_done", 32'(done), 32'h0);
    rst = 1'b0;
    set_req(0, 1'b0, 8'h10, 4'd2, 32'h0);
    set_req(1, 1'b0, 8'h30, 4'd0, 32'h0);
    req = 3'b011;
    #1 chk("post_idle_gnt", 32'(gnt), 32'h0);
    cyc();
    req = 3'b000;
    #1 chk("post_first_gnt", 32'(gnt), 32'h1);
    for (int k = 1; k < 4; k++) begin
      cyc();
      #1;
      if (k < 3) chk("post_gnt", 32'(gnt), 32'h1);
      chk("post_rvalid", 32'(rvalid), 32'h1);
      chk("post_rdata", rdata, (k == 1) ? 32'hD0 : (k == 2) ? 32'hD1 : 32'hA2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gbuff_arbiter.md
Name: gbuff_arbiter

Overview:
Shares the single-port 256x32 global buffer between three requesters: host loader, operand fetch and result writeback. Each requester issues bursts of 1-16 consecutive words. The arbiter picks one requester round-robin, then drives the buffer's wr_en/index/data_in for the whole burst. Read data is returned with a one-cycle-later valid strobe. The block sits between the TPU control/datapath and the global buffer instance.

Parameters:
ADDR_W, 8, buffer index width (256 words)
DATA_W, 32, word width
LEN_W, 4, burst length field width (beats = len+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  3  per-requester burst request, bit i = requester i
we  in  3  per-requester direction, 1 = write, 0 = read
addr  in  3*ADDR_W  per-requester start index; requester i uses slice [i*ADDR_W +: ADDR_W]
wdata  in  3*DATA_W  per-requester write data for the current beat
len  in  3*LEN_W  per-requester burst length minus one
gnt  out  3  one-hot; bit i high = a beat of requester i is issued this cycle
done  out  3  one-hot pulse, concurrent with the last gnt of a burst
rvalid  out  3  one-hot; read data for requester i is on rdata this cycle
rdata  out  DATA_W  read data, shared by all requesters
gb_wr_en  out  1  to buffer: 1 = write, 0 = read
gb_index  out  ADDR_W  to buffer: word index
gb_data_in  out  DATA_W  to buffer: write data
gb_data_out  in  DATA_W  from buffer: registered read data

Behaviour:
- Reset (asynchronous, any cycle, including mid-burst):
  - state=IDLE, rr_ptr=2, so requester 0 wins first.
  - gnt=0, done=0, rvalid=0, gb_wr_en=0, gb_index=0, owner=0, beat=0.
  - Any burst in flight is aborted: no done pulse, no pending rvalid.
- FSM IDLE:
  - Sample req. If req=0, stay IDLE with gb_wr_en=0.
  - Otherwise pick the winner by searching rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 3); the first set bit wins.
  - At the clock edge, latch owner, we, addr and len into registers, set beat=0, rr_ptr=owner, and go to BURST.
- FSM BURST:
  - gnt[owner]=1 every cycle.
  - gb_index = latched addr + beat, mod 256. Index 255 wraps to 0.
  - gb_wr_en = latched we.
  - gb_data_in = wdata slice of owner, combinational, so the requester's current beat data passes straight through.
  - When beat == latched len: done[owner]=1, and at the next edge go to IDLE.
  - Otherwise beat increments at the edge.
- Timing:
  - Grant latency is 1 cycle after req is seen in IDLE.
  - There is exactly one IDLE bubble between consecutive bursts.
- Write beats:
  - The requester holds wdata for beat k until it sees gnt high for one cycle, then presents beat k+1 in the next cycle.
- Read return:
  - rvalid[i] is registered gnt[i] AND NOT we, delayed 1 cycle.
  - rdata = gb_data_out in that cycle.
  - Reads return in order, one word per cycle. The last rvalid follows done by 1 cycle.
- Request handling:
  - req, addr, len and we are sampled only at the grant edge. Changes during a burst are ignored.
  - Dropping req mid-burst does not abort the burst.
  - A requester that keeps req high after done re-enters arbitration but yields to other pending requesters (round-robin).
- Invariants:
  - gnt, done and rvalid are each at most one-hot.
  - gnt and done are never high in IDLE.
  - gb_wr_en=1 only in BURST with latched we=1.
- Arithmetic: beat is LEN_W bits. The index adder is ADDR_W bits and drops the carry.

Test Plan:
- Single write: req0, we=1, addr=0x10, len=3, wdata 0xA0..0xA3 -> gnt[0] high cycles 1-4, gb_index 0x10-0x13, gb_wr_en=1, done[0] in cycle 4; buffer holds 0xA0..0xA3.
- Read back: req1, we=0, addr=0x10, len=3 -> rvalid[1] in cycles 2-5, rdata 0xA0,0xA1,0xA2,0xA3; gb_wr_en=0 throughout.
- Wrap: req2 write addr=0xFE, len=2 -> gb_index 0xFE, 0xFF, 0x00.
- Fairness: all three req held high with len=0 -> grants after reset go 0,1,2,0,1,2, with one IDLE cycle between each.
- Late change: req0 raised one cycle after the arbiter has already granted requester 1 -> requester 0 waits for requester 1's done; changing addr1 mid-burst has no effect on gb_index.
- Reset mid-burst: assert rst during beat 2 of a len=7 write -> all outputs 0 immediately, no done, no further writes; after release, req0 is granted first.
